hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Parametrised pipeline hazard controller for the next-generation 5-stage Astrio core (IF, ID, EX, MEM, WB).
- Tracks in-flight register writes from EX onward in an internal scoreboard shift register.
- Generates an IF/ID stall with an EX bubble for load-use hazards, and an IF flush on ID-resolved redirects.
- Drives per-operand forwarding selects for the EX stage, for any number of source operands and forwarding stages.

Parameters:
- REG_ID_W, 5: register index width.
- NUM_SRC, 2: source operands per instruction.
- FWD_DEPTH, 2: forwarding stages behind EX. Index 1 = MEM, 2 = WB. Range 1..7.
- LOAD_LAT, 2: lowest tracker index whose forwarded value is valid for a load. Range 1..FWD_DEPTH.
- SEL_W, $clog2(FWD_DEPTH+1): forwarding select width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_ID_W  ID source register ids; operand i is at slice i.
- id_rs_used  in  NUM_SRC  per-operand "source is actually read".
- id_we  in  1  ID instruction writes a register.
- id_rd  in  REG_ID_W  ID destination id.
- id_is_load  in  1  ID instruction is a load.
- id_redirect  in  1  ID resolved a taken branch/jump this cycle.
- stall  out  1  hold PC and IF/ID; ID->EX register loads a bubble.
- flush  out  1  IF/ID register loads NOP next edge.
- ex_fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = ID-read value, k = result held at tracker index k.

Behaviour:
- Tracker: entries 0..FWD_DEPTH of {valid, we, is_load, rd}. Entry 0 = instruction in EX.
  - Also holds ex_rs/ex_rs_used for the EX instruction.
- Live match at entry k for source i: entry valid, we=1, rd!=0, rd==id_rs[i] (or ex_rs[i] for forwarding), and used bit set.
- stall = id_valid AND any source i has a live match at entry k where entry.is_load=1 and k <= LOAD_LAT-2.
  - With defaults, this means a load in EX gives exactly 1 stall cycle.
  - LOAD_LAT=1: stall is never asserted.
- flush = id_valid AND id_redirect AND NOT stall.
  - A stalled redirect is re-presented by ID next cycle and re-evaluated then.
- Update each edge when rst=1:
  - entry[k+1] <= entry[k].
  - entry[0] <= stall ? empty : {id_valid, id_we, id_is_load, id_rd}.
  - ex_rs, ex_rs_used <= stall ? 0 : id_rs, id_rs_used.
  - The redirecting instruction itself issues normally, e.g. jal writing $31.
- ex_fwd_sel[i]: smallest k in 1..FWD_DEPTH with a live match on ex_rs[i]; youngest wins. Otherwise 0.
  - A load match at k < LOAD_LAT is unreachable by construction; assertion required.
- Producers older than FWD_DEPTH: the register file is write-before-read; this block takes no action.
- Reset (rst=0 at an edge): all entries and ex_rs cleared.
  - While rst=0, stall, flush and ex_fwd_sel are forced to 0 combinationally.
  - A mid-stall reset drops the stall in the same cycle.
- Simultaneous stall and redirect: stall wins; flush=0.
- id_valid=0: stall=0, flush=0, a bubble enters the tracker.
- Register 0 is never a hazard.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stat_stalls (32) and stat_flushes (32).
  - Counters increment on each cycle stall or flush is high.
  - Saturate at 0xFFFF_FFFF; cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package HazardType: track_entry_t struct {valid, we, is_load, rd}, fwd_sel_t, and constant FWD_NONE = 0.
- One sub-module, hazard_tracker: the parametrised shift register of track_entry_t with bubble insert and synchronous clear.
- Match and priority logic stays in hazard_unit.

Test Plan:
- lw $2 issues, then add $3,$2,$4 in ID -> stall=1 for exactly 1 cycle. When the add reaches EX: ex_fwd_sel[0]=2, ex_fwd_sel[1]=0.
- add $5,$1,$1 then sub $6,$5,$5 back-to-back -> stall=0; the sub in EX has ex_fwd_sel[0]=ex_fwd_sel[1]=1.
- add $7 then or $7 then and $8,$7,$0 -> and in EX has ex_fwd_sel[0]=1 (youngest), ex_fwd_sel[1]=0 ($0 ignored).
- beq taken (id_redirect=1) with no hazard -> flush=1 for 1 cycle. Repeat with a lw dependency -> flush=0 while stall=1, then flush=1 on the next cycle.
- Source matching rd but id_rs_used=0 -> stall=0, ex_fwd_sel=0. Source $0 matching a load to $0 -> stall=0.
- Assert rst=0 during a stall -> stall=0 immediately; after release, the tracker is empty and ex_fwd_sel=0. With HAZARD_STATS_EN, stat_stalls=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the Astrio hazard controller: tracker entry layout,
// forwarding select type and the operand/entry match helper.
package hazard_unit_pkg;

  // rd is stored at a fixed maximum width so the struct stays unparametrised.
  localparam int RD_MAX_W  = 16;
  localparam int SEL_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic                is_load;
    logic [RD_MAX_W-1:0] rd;
  } track_entry_t;

  typedef logic [SEL_MAX_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE = 3'd0;

  function automatic logic entry_hits(input track_entry_t e,
                                      input logic [RD_MAX_W-1:0] rs,
                                      input logic used);
    return e.valid && e.we && (e.rd != {RD_MAX_W{1'b0}}) && (e.rd == rs) && used;
  endfunction

endpackage

// File: rtl/hazard_tracker.sv
// In-flight write tracker: entry 0 is the EX instruction, higher indices are
// progressively older. Bubbles enter on request; synchronous active-low clear.
module hazard_tracker
  import hazard_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bubble,
  input  track_entry_t             i_insert,
  output track_entry_t [DEPTH:0]   o_entries
);

  track_entry_t [DEPTH:0] r_entries;
  track_entry_t           w_in;

  // Select the incoming entry: a real instruction or an empty bubble.
  always_comb begin
    if (i_bubble) begin
      w_in = {$bits(track_entry_t){1'b0}};
    end else begin
      w_in = i_insert;
    end
  end

  // Shift every entry one stage older each cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_entries <= {($bits(track_entry_t)*(DEPTH+1)){1'b0}};
    end else begin
      r_entries <= {r_entries[DEPTH-1:0], w_in};
    end
  end

  assign o_entries = r_entries;

endmodule

// File: rtl/hazard_unit_chk.sv
// Runtime checker: a load must never be chosen as a forwarding source before
// its data is available.
module hazard_unit_chk (
  input logic clk,
  input logic rst,
  input logic i_early_load
);

  // Flag any forwarding select that points at a not-yet-ready load.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!i_early_load) else $error("hazard_unit: load forwarded before data ready");
    end else begin
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, redirect flush and EX forwarding selects for the 5-stage core.
// Define HAZARD_STATS_EN to add saturating stat_stalls/stat_flushes counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_ID_W  = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_ID_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic                        id_we,
  input  logic [REG_ID_W-1:0]         id_rd,
  input  logic                        id_is_load,
  input  logic                        id_redirect,
  output logic                        stall,
  output logic                        flush,
  output logic [NUM_SRC*SEL_W-1:0]    ex_fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                 stat_stalls,
  output logic [31:0]                 stat_flushes
`endif
);

  track_entry_t [FWD_DEPTH:0]  w_entries;
  track_entry_t                w_insert;
  logic [NUM_SRC*REG_ID_W-1:0] r_ex_rs;
  logic [NUM_SRC-1:0]          r_ex_rs_used;
  logic                        w_load_use;
  logic [SEL_W-1:0]            w_sel [NUM_SRC];
  logic [NUM_SRC-1:0]          w_early;

  assign w_insert.valid   = id_valid;
  assign w_insert.we      = id_we;
  assign w_insert.is_load = id_is_load;
  assign w_insert.rd      = RD_MAX_W'(id_rd);

  hazard_tracker #(.DEPTH(FWD_DEPTH)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_bubble  (stall || !id_valid),
    .i_insert  (w_insert),
    .o_entries (w_entries)
  );

  // Load-use detection: an ID source hits a load too young to forward from.
  always_comb begin
    w_load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        if ((k <= LOAD_LAT - 2) && w_entries[k].is_load &&
            entry_hits(w_entries[k], RD_MAX_W'(id_rs[i*REG_ID_W +: REG_ID_W]), id_rs_used[i])) begin
          w_load_use = 1'b1;
        end else begin
          w_load_use = w_load_use;
        end
      end
    end
  end

  assign stall = rst && id_valid && w_load_use;
  assign flush = rst && id_valid && id_redirect && !w_load_use;

  // Forwarding priority: scan oldest to youngest so the youngest hit wins.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel[i]   = SEL_W'(FWD_NONE);
      w_early[i] = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (entry_hits(w_entries[k], RD_MAX_W'(r_ex_rs[i*REG_ID_W +: REG_ID_W]), r_ex_rs_used[i])) begin
          w_sel[i]   = SEL_W'(k);
          w_early[i] = w_entries[k].is_load && (k < LOAD_LAT);
        end else begin
          w_sel[i]   = w_sel[i];
          w_early[i] = w_early[i];
        end
      end
    end
  end

  // Outputs are held at zero while reset is asserted.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rst) begin
        ex_fwd_sel[i*SEL_W +: SEL_W] = w_sel[i];
      end else begin
        ex_fwd_sel[i*SEL_W +: SEL_W] = {SEL_W{1'b0}};
      end
    end
  end

  // EX source ids follow the instruction into EX; bubbles carry no sources.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_rs      <= {(NUM_SRC*REG_ID_W){1'b0}};
      r_ex_rs_used <= {NUM_SRC{1'b0}};
    end else if (stall || !id_valid) begin
      r_ex_rs      <= {(NUM_SRC*REG_ID_W){1'b0}};
      r_ex_rs_used <= {NUM_SRC{1'b0}};
    end else begin
      r_ex_rs      <= id_rs;
      r_ex_rs_used <= id_rs_used;
    end
  end

  hazard_unit_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_early_load (|w_early)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stalls;
  logic [31:0] r_stat_flushes;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_stalls  <= 32'd0;
      r_stat_flushes <= 32'd0;
    end else begin
      if (stall && (r_stat_stalls != 32'hFFFF_FFFF)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end else begin
        r_stat_stalls <= r_stat_stalls;
      end
      if (flush && (r_stat_flushes != 32'hFFFF_FFFF)) begin
        r_stat_flushes <= r_stat_flushes + 32'd1;
      end else begin
        r_stat_flushes <= r_stat_flushes;
      end
    end
  end

  assign stat_stalls  = r_stat_stalls;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule
